// File: rtl/solver_arbiter_if.sv
// Requester/solver bus for solver_arbiter: NUM_REQ requesters share one solver.
// Reductions are two's-complement RED_W-bit values carried as plain bit vectors.
interface solver_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int RED_W   = 19
);
    logic [NUM_REQ-1:0]   req_val;
    logic [NUM_REQ-1:0]   req_rdy;
    logic [NUM_REQ*9-1:0] req_p1x;
    logic [NUM_REQ*9-1:0] req_p1y;
    logic [NUM_REQ*9-1:0] req_p2x;
    logic [NUM_REQ*9-1:0] req_p2y;
    logic [NUM_REQ-1:0]   req_change;
    logic [NUM_REQ*2-1:0] req_mode;
    logic [NUM_REQ-1:0]   resp_val;
    logic [NUM_REQ-1:0]   resp_rdy;
    logic [RED_W-1:0]     resp_reduction;

    logic                 sol_req_val;
    logic                 sol_req_rdy;
    logic [8:0]           sol_p1x;
    logic [8:0]           sol_p1y;
    logic [8:0]           sol_p2x;
    logic [8:0]           sol_p2y;
    logic                 sol_change;
    logic [1:0]           sol_mode;
    logic                 sol_resp_val;
    logic                 sol_resp_rdy;
    logic [RED_W-1:0]     sol_reduction;

    logic [2:0]           grant_id;
    logic                 busy;

    // Arbiter side
    modport slave (
        input  req_val, req_p1x, req_p1y, req_p2x, req_p2y, req_change, req_mode, resp_rdy,
               sol_req_rdy, sol_resp_val, sol_reduction,
        output req_rdy, resp_val, resp_reduction, sol_req_val, sol_p1x, sol_p1y, sol_p2x,
               sol_p2y, sol_change, sol_mode, sol_resp_rdy, grant_id, busy
    );

    // Requesters plus solver
    modport master (
        output req_val, req_p1x, req_p1y, req_p2x, req_p2y, req_change, req_mode, resp_rdy,
               sol_req_rdy, sol_resp_val, sol_reduction,
        input  req_rdy, resp_val, resp_reduction, sol_req_val, sol_p1x, sol_p1y, sol_p2x,
               sol_p2y, sol_change, sol_mode, sol_resp_rdy, grant_id, busy
    );
endinterface

// File: rtl/solver_arbiter.sv
// Shares one Bresenham solver among NUM_REQ requesters, one transaction at a time.
// Update requests beat search requests; round-robin within each class.
module solver_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int RED_W   = 19
) (
    input logic             clk,
    input logic             reset,
    solver_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t               state_q, state_d;
    logic [2:0]           last_q, last_d;
    logic [2:0]           grant_q, grant_d;
    logic [8:0]           p1x_q, p1x_d, p1y_q, p1y_d, p2x_q, p2x_d, p2y_q, p2y_d;
    logic                 change_q, change_d;
    logic [1:0]           mode_q, mode_d;
    logic [RED_W-1:0]     red_q, red_d;

    logic [NUM_REQ-1:0]   upd_mask, cand_mask, req_rdy_c, grant_oh;
    logic [2:0]           win;

    // First set bit of m scanning upward from last+1, wrapping modulo NUM_REQ.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] m, input logic [2:0] last);
        logic [2:0]         w;
        logic [NUM_REQ-1:0] sh;
        int                 idx;
        w = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            sh  = m >> idx;
            if (sh[0]) w = 3'(idx);
        end
        return w;
    endfunction

    always_comb begin
        upd_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) upd_mask[i] = bus.req_val[i] & bus.req_mode[2*i];
        cand_mask = (|upd_mask) ? upd_mask : bus.req_val;
        win       = rr_pick(cand_mask, last_q);
        grant_oh  = NUM_REQ'(1) << grant_q;
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        p1x_d     = p1x_q;
        p1y_d     = p1y_q;
        p2x_d     = p2x_q;
        p2y_d     = p2y_q;
        change_d  = change_q;
        mode_d    = mode_q;
        red_d     = red_q;
        req_rdy_c = '0;
        case (state_q)
            IDLE: begin
                if (reset && |bus.req_val) begin
                    req_rdy_c = NUM_REQ'(1) << win;
                    grant_d   = win;
                    last_d    = win;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (win == 3'(i)) begin
                            p1x_d    = bus.req_p1x[i*9 +: 9];
                            p1y_d    = bus.req_p1y[i*9 +: 9];
                            p2x_d    = bus.req_p2x[i*9 +: 9];
                            p2y_d    = bus.req_p2y[i*9 +: 9];
                            change_d = bus.req_change[i];
                            mode_d   = bus.req_mode[i*2 +: 2];
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE:   if (bus.sol_req_rdy) state_d = WAIT;
            WAIT: begin
                if (bus.sol_resp_val) begin
                    red_d   = bus.sol_reduction;
                    state_d = DELIVER;
                end
            end
            DELIVER: if (|(bus.resp_rdy & grant_oh)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_q   <= 3'(NUM_REQ - 1);
            grant_q  <= '0;
            p1x_q    <= '0;
            p1y_q    <= '0;
            p2x_q    <= '0;
            p2y_q    <= '0;
            change_q <= 1'b0;
            mode_q   <= '0;
            red_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            p1x_q    <= p1x_d;
            p1y_q    <= p1y_d;
            p2x_q    <= p2x_d;
            p2y_q    <= p2y_d;
            change_q <= change_d;
            mode_q   <= mode_d;
            red_q    <= red_d;
        end
    end

    // Handshake outputs are held low while reset is asserted, even mid-transaction.
    assign bus.req_rdy        = req_rdy_c;
    assign bus.sol_req_val    = reset && (state_q == ISSUE);
    assign bus.sol_resp_rdy   = reset && (state_q == WAIT);
    assign bus.resp_val       = (reset && (state_q == DELIVER)) ? grant_oh : '0;
    assign bus.busy           = reset && (state_q != IDLE);
    assign bus.grant_id       = grant_q;
    assign bus.resp_reduction = red_q;
    assign bus.sol_p1x        = p1x_q;
    assign bus.sol_p1y        = p1y_q;
    assign bus.sol_p2x        = p2x_q;
    assign bus.sol_p2y        = p2y_q;
    assign bus.sol_change     = change_q;
    assign bus.sol_mode       = mode_q;
endmodule

// File: tb/tb_solver_arbiter.sv
// Directed bench for solver_arbiter: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_solver_arbiter;
    localparam int N  = 4;
    localparam int RW = 19;

    logic clk, reset;
    solver_arbiter_if #(.NUM_REQ(N), .RED_W(RW)) bus ();
    solver_arbiter #(.NUM_REQ(N), .RED_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit sticky = 1'b0;

    // Model: phase 0 idle, 1 issuing, 2 awaiting solver, 3 delivering.
    int          m_ph, m_own, m_last;
    logic [8:0]  m_p1x, m_p1y, m_p2x, m_p2y;
    logic        m_chg;
    logic [1:0]  m_mode;
    logic [RW-1:0] m_red;

    logic [N-1:0]  s_req_rdy, s_resp_val;
    logic          s_sol_req_val, s_sol_resp_rdy, s_busy;
    logic [8:0]    s_p1x, s_p1y, s_p2x, s_p2y;
    logic [RW-1:0] s_red;
    logic [2:0]    s_gid;
    int            glog[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic bit bit_of(input logic [63:0] v, input int i);
        logic [63:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Candidates listed in rotation order from last grant; updates first.
    function automatic int m_pick();
        int qu[$];
        int qs[$];
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (bit_of(64'(bus.req_val), i)) begin
                if (bit_of(64'(bus.req_mode), 2 * i)) qu.push_back(i);
                else qs.push_back(i);
            end
        end
        if (qu.size() > 0) return qu[0];
        if (qs.size() > 0) return qs[0];
        return 0;
    endfunction

    task automatic m_reset();
        m_ph = 0; m_own = 0; m_last = N - 1;
        m_p1x = '0; m_p1y = '0; m_p2x = '0; m_p2y = '0;
        m_chg = 1'b0; m_mode = '0; m_red = '0;
    endtask

    task automatic model_update();
        int w;
        if (!reset) begin
            m_reset();
        end else begin
            case (m_ph)
                0: if (bus.req_val != '0) begin
                    w      = m_pick();
                    m_own  = w;
                    m_last = w;
                    m_p1x  = 9'(bus.req_p1x >> (w * 9));
                    m_p1y  = 9'(bus.req_p1y >> (w * 9));
                    m_p2x  = 9'(bus.req_p2x >> (w * 9));
                    m_p2y  = 9'(bus.req_p2y >> (w * 9));
                    m_chg  = bit_of(64'(bus.req_change), w);
                    m_mode = 2'(bus.req_mode >> (w * 2));
                    m_ph   = 1;
                end
                1: if (bus.sol_req_rdy) m_ph = 2;
                2: if (bus.sol_resp_val) begin
                    m_red = bus.sol_reduction;
                    m_ph  = 3;
                end
                default: if (bit_of(64'(bus.resp_rdy), m_own)) m_ph = 0;
            endcase
        end
    endtask

    task automatic check_all();
        logic [N-1:0] er, ev;
        er = '0;
        ev = '0;
        if (reset && m_ph == 0 && bus.req_val != '0) er = N'(1) << m_pick();
        if (reset && m_ph == 3) ev = N'(1) << m_own;
        chk("req_rdy", 64'(bus.req_rdy), 64'(er));
        chk("resp_val", 64'(bus.resp_val), 64'(ev));
        chk("sol_req_val", 64'(bus.sol_req_val), 64'(reset && m_ph == 1));
        chk("sol_resp_rdy", 64'(bus.sol_resp_rdy), 64'(reset && m_ph == 2));
        chk("busy", 64'(bus.busy), 64'(reset && m_ph != 0));
        chk("grant_id", 64'(bus.grant_id), 64'(m_own));
        chk("sol_p1x", 64'(bus.sol_p1x), 64'(m_p1x));
        chk("sol_p1y", 64'(bus.sol_p1y), 64'(m_p1y));
        chk("sol_p2x", 64'(bus.sol_p2x), 64'(m_p2x));
        chk("sol_p2y", 64'(bus.sol_p2y), 64'(m_p2y));
        chk("sol_change", 64'(bus.sol_change), 64'(m_chg));
        chk("sol_mode", 64'(bus.sol_mode), 64'(m_mode));
        chk("resp_reduction", 64'(bus.resp_reduction), 64'(m_red));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        s_req_rdy = bus.req_rdy;   s_resp_val = bus.resp_val;
        s_sol_req_val = bus.sol_req_val; s_sol_resp_rdy = bus.sol_resp_rdy;
        s_busy = bus.busy; s_gid = bus.grant_id; s_red = bus.resp_reduction;
        s_p1x = bus.sol_p1x; s_p1y = bus.sol_p1y; s_p2x = bus.sol_p2x; s_p2y = bus.sol_p2y;
        for (int i = 0; i < N; i++) if (bus.req_rdy == (N'(1) << i)) glog.push_back(i);
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        if (!sticky) bus.req_val = bus.req_val & ~s_req_rdy;
    endtask

    task automatic set_req(input int i, input int x1, input int y1, input int x2, input int y2,
                           input bit chg, input int mode);
        bus.req_p1x    = (bus.req_p1x & ~((N*9)'(9'h1FF) << (i*9))) | ((N*9)'(9'(x1)) << (i*9));
        bus.req_p1y    = (bus.req_p1y & ~((N*9)'(9'h1FF) << (i*9))) | ((N*9)'(9'(y1)) << (i*9));
        bus.req_p2x    = (bus.req_p2x & ~((N*9)'(9'h1FF) << (i*9))) | ((N*9)'(9'(x2)) << (i*9));
        bus.req_p2y    = (bus.req_p2y & ~((N*9)'(9'h1FF) << (i*9))) | ((N*9)'(9'(y2)) << (i*9));
        bus.req_change = (bus.req_change & ~(N'(1) << i)) | (N'(chg) << i);
        bus.req_mode   = (bus.req_mode & ~((N*2)'(2'b11) << (i*2))) | ((N*2)'(2'(mode)) << (i*2));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Steps until resp_val is seen (bounded); result tells whether it arrived.
    task automatic wait_resp(input string nm, input int limit);
        bit got;
        got = 1'b0;
        for (int k = 0; k < limit && !got; k++) begin
            step();
            if (s_resp_val != '0) got = 1'b1;
        end
        chk(nm, 64'(got), 64'd1);
    endtask

    initial begin
        int t_rdy, t_resp;
        logic [N-1:0]  rv;
        logic [RW-1:0] rr;
        logic [8:0]    c1x, c1y, c2x, c2y;
        int o2[5];
        int o3[3];
        bit got;

        m_reset();
        reset = 1'b0;
        bus.req_val = '0; bus.req_p1x = '0; bus.req_p1y = '0; bus.req_p2x = '0; bus.req_p2y = '0;
        bus.req_change = '0; bus.req_mode = '0; bus.resp_rdy = '0;
        bus.sol_req_rdy = 1'b0; bus.sol_resp_val = 1'b0; bus.sol_reduction = '0;
        step();
        step();
        chk("reset_busy", 64'(s_busy), 64'd0);
        chk("reset_grant_id", 64'(s_gid), 64'd0);
        chk("reset_reduction", 64'(s_red), 64'd0);
        reset = 1'b1;

        // Single requester 2, solver answers 37 immediately
        bus.resp_rdy = '1; bus.sol_req_rdy = 1'b1; bus.sol_resp_val = 1'b1; bus.sol_reduction = 19'd37;
        set_req(2, 10, 20, 200, 150, 1'b0, 0);
        bus.req_val = 4'b0100;
        glog.delete();
        t_rdy = -1; t_resp = -1; rv = '0; rr = '0; c1x = '0; c1y = '0; c2x = '0; c2y = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_req_rdy != '0 && t_rdy < 0) t_rdy = cyc;
            if (s_sol_req_val) begin c1x = s_p1x; c1y = s_p1y; c2x = s_p2x; c2y = s_p2y; end
            if (s_resp_val != '0 && t_resp < 0) begin t_resp = cyc; rv = s_resp_val; rr = s_red; end
        end
        chk("t1_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd2);
        chk("t1_resp_val", 64'(rv), 64'b0100);
        chk("t1_reduction", 64'(rr), 64'd37);
        chk("t1_latency", 64'(t_resp - t_rdy), 64'd3);
        chk("t1_p1x", 64'(c1x), 64'd10);
        chk("t1_p1y", 64'(c1y), 64'd20);
        chk("t1_p2x", 64'(c2x), 64'd200);
        chk("t1_p2y", 64'(c2y), 64'd150);

        // All four searching continuously: fair rotation from requester 0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, i + 1, i + 2, i + 3, i + 4, 1'b0, 0);
        sticky = 1'b1;
        bus.req_val = 4'hF;
        glog.delete();
        for (int k = 0; k < 20; k++) step();
        sticky = 1'b0;
        bus.req_val = '0;
        o2 = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) chk("t2_rr_order", 64'(i < glog.size() ? glog[i] : -1), 64'(o2[i]));
        for (int k = 0; k < 4; k++) step();

        // Update on 1 wins first; then searches 3 and 0 rotate from last grant 1
        do_reset();
        set_req(0, 5, 6, 7, 8, 1'b0, 0);
        set_req(1, 9, 10, 11, 12, 1'b1, 3);
        set_req(2, 0, 0, 0, 0, 1'b0, 0);
        set_req(3, 13, 14, 15, 16, 1'b0, 0);
        bus.req_val = 4'b1011;
        glog.delete();
        for (int k = 0; k < 14; k++) step();
        o3 = '{1, 3, 0};
        chk("t3_count", 64'(glog.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk("t3_prio_order", 64'(i < glog.size() ? glog[i] : -1), 64'(o3[i]));

        // Solver stalls 5 cycles in ISSUE while a stray response is offered
        set_req(1, 1, 2, 3, 4, 1'b1, 1);
        bus.sol_req_rdy = 1'b0; bus.sol_resp_val = 1'b1; bus.sol_reduction = 19'd555;
        bus.req_val = 4'b0010;
        step();
        chk("t4_req_rdy", 64'(s_req_rdy), 64'b0010);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_stall_sol_req_val", 64'(s_sol_req_val), 64'd1);
            chk("t4_stall_p1x", 64'(s_p1x), 64'd1);
            chk("t4_stall_p2y", 64'(s_p2y), 64'd4);
            chk("t4_stall_no_resp", 64'(s_resp_val), 64'd0);
        end
        bus.sol_req_rdy = 1'b1; bus.sol_reduction = 19'd99;
        wait_resp("t4_resp_timeout", 10);
        chk("t4_resp_val", 64'(s_resp_val), 64'b0010);
        chk("t4_reduction", 64'(s_red), 64'd99);
        step();

        // Negative reduction held while requester 3 is not ready
        set_req(3, 100, 101, 102, 103, 1'b0, 0);
        bus.resp_rdy = '0; bus.sol_reduction = 19'h7FFFB;
        bus.req_val = 4'b1000;
        wait_resp("t5_resp_timeout", 10);
        set_req(0, 30, 31, 32, 33, 1'b0, 0);
        bus.req_val = 4'b0001;
        bus.resp_rdy = 4'b0111;
        chk("t5_resp_val", 64'(s_resp_val), 64'b1000);
        chk("t5_reduction", 64'(s_red), 64'h7FFFB);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t5_hold_resp_val", 64'(s_resp_val), 64'b1000);
            chk("t5_hold_no_req_rdy", 64'(s_req_rdy), 64'd0);
        end
        bus.resp_rdy = 4'b1000;
        step();
        chk("t5_last_resp_val", 64'(s_resp_val), 64'b1000);
        step();
        chk("t5_next_grant", 64'(s_req_rdy), 64'b0001);

        // Reset while waiting on the solver abandons the transaction
        bus.resp_rdy = '1; bus.sol_resp_val = 1'b0; bus.sol_req_rdy = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            step();
            if (s_sol_resp_rdy) got = 1'b1;
        end
        chk("t6_reach_wait", 64'(got), 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("t6_busy", 64'(s_busy), 64'd0);
        chk("t6_resp_val", 64'(s_resp_val), 64'd0);
        chk("t6_sol_req_val", 64'(s_sol_req_val), 64'd0);
        chk("t6_sol_resp_rdy", 64'(s_sol_resp_rdy), 64'd0);
        chk("t6_grant_id", 64'(s_gid), 64'd0);
        bus.sol_resp_val = 1'b1; bus.sol_reduction = 19'd7;
        set_req(3, 40, 41, 42, 43, 1'b0, 0);
        bus.req_val = 4'b1001;
        step();
        chk("t6_first_grant", 64'(s_req_rdy), 64'b0001);
        for (int k = 0; k < 10; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
